// File: rtl/dfi_bist_seq_ctrl_v1_0.sv
// Step sequencer for the DFI BIST top: load config, clear checker, run, stop, grade, repeat per table entry.
// Optional SEQ_ERR_STOP_EN: end the sequence at the first step whose CHECK records a failure.
module dfi_bist_seq_ctrl_v1_0 #(
   parameter int                      NUM_STEPS    = 4,
   parameter logic [NUM_STEPS*22-1:0] STEP_CFG     = '0,
   parameter logic [23:0]             RUN_CYCLES   = 24'd1000000,
   parameter int                      SETTLE_CYC   = 16,
   parameter int                      STOP_TIMEOUT = 4096
) (
   input  logic                 core_clk,
   input  logic                 core_clk_rst_n,
   input  logic                 seq_start,
   input  logic                 seq_abort,
   input  logic                 ddrphy_init_done,
   input  logic                 bist_run_led,
   input  logic [7:0]           err_cnt,
   input  logic                 err_flag_led,
   output logic [1:0]           wr_mode,
   output logic [1:0]           data_mode,
   output logic                 len_random_en,
   output logic [3:0]           fix_wr_len,
   output logic [3:0]           read_repeat_num,
   output logic                 data_order,
   output logic [7:0]           dq_inversion,
   output logic                 bist_stop,
   output logic                 manu_clear,
   output logic [3:0]           step_idx,
   output logic [NUM_STEPS-1:0] fail_mask,
   output logic                 seq_busy,
   output logic                 seq_done,
   output logic                 seq_pass,
   output logic                 seq_timeout,
   output logic [2:0]           seq_state
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_INIT = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_SETTLE    = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_STOP      = 3'd5;
   localparam logic [2:0] S_CHECK     = 3'd6;
   localparam logic [2:0] S_DONE      = 3'd7;

   localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYC - 1);
   localparam logic [23:0] RUN_LAST    = RUN_CYCLES - 24'd1;
   localparam logic [23:0] TMO_LAST    = 24'(STOP_TIMEOUT - 1);
   localparam logic [3:0]  LAST_STEP   = 4'(NUM_STEPS - 1);

   // Table padded to 16 entries so the 4-bit step index addresses it directly.
   logic [21:0] cfg_tab [16];
   for (genvar g = 0; g < 16; g++) begin : g_tab
      if (g < NUM_STEPS) begin : g_used
         assign cfg_tab[g] = STEP_CFG[22*g +: 22];
      end else begin : g_pad
         assign cfg_tab[g] = '0;
      end
   end

   logic [2:0]  state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [3:0]  step_q, step_d;
   logic [15:0] fail_q, fail_d;
   logic [21:0] cfg_q, cfg_d;
   logic [2:0]  clr_q, clr_d;
   logic        stop_q, stop_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        tmo_q, tmo_d;
   logic        abort_q, abort_d;
   logic        abort_req;
   logic        stop_exit;
   logic        step_err;

   // Loss of PHY init while a sequence owns the BIST is handled exactly like an abort.
   assign abort_req = seq_abort | ~ddrphy_init_done;
   assign step_err  = (err_cnt != '0) | err_flag_led;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 24'd1;
      step_d    = step_q;
      fail_d    = fail_q;
      cfg_d     = cfg_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      tmo_d     = tmo_q;
      abort_d   = abort_q;
      stop_exit = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (seq_start && !seq_abort) begin
               state_d = S_WAIT_INIT;
               cnt_d   = '0;
               step_d  = '0;
               fail_d  = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               tmo_d   = 1'b0;
               abort_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_WAIT_INIT: begin
            if (seq_abort) begin
               state_d = S_STOP;
               abort_d = 1'b1;
               cnt_d   = '0;
            end else if (ddrphy_init_done) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            cfg_d = cfg_tab[step_q];
            cnt_d = '0;
            if (abort_req) begin
               state_d = S_STOP;
               abort_d = 1'b1;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort_req) begin
               state_d = S_STOP;
               abort_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (abort_req) begin
               state_d = S_STOP;
               abort_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == RUN_LAST) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end
         end
         S_STOP: begin
            // cnt_q != 0 enforces two STOP cycles so bist_run_led reflects the stop request.
            if (abort_req) abort_d = 1'b1;
            if (cnt_q != '0 && !bist_run_led) begin
               stop_exit = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               stop_exit      = 1'b1;
               tmo_d          = 1'b1;
               fail_d[step_q] = 1'b1;
            end
            if (stop_exit) begin
               cnt_d   = '0;
               state_d = abort_d ? S_DONE : S_CHECK;
            end
         end
         S_CHECK: begin
            cnt_d = '0;
            if (step_err) fail_d[step_q] = 1'b1;
            if (abort_req) begin
               abort_d = 1'b1;
               state_d = S_DONE;
            end else if (step_q == LAST_STEP) begin
               state_d = S_DONE;
`ifdef SEQ_ERR_STOP_EN
            end else if (fail_d[step_q]) begin
               state_d = S_DONE;
`else
`endif
            end else begin
               step_d  = step_q + 4'd1;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_DONE && state_q != S_DONE) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         pass_d = (fail_d == '0) & ~abort_d;
      end
   end

   // bist_stop is registered from the next state so it is low exactly while the FSM sits in RUN.
   assign stop_d = (state_d != S_RUN);

   always_comb begin
      clr_d = clr_q;
      if (state_d == S_LOAD && state_q != S_LOAD) clr_d = 3'd4;
      else if (clr_q != '0)                       clr_d = clr_q - 3'd1;
   end

   always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
      if (!core_clk_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         fail_q  <= '0;
         cfg_q   <= '0;
         clr_q   <= '0;
         stop_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         fail_q  <= fail_d;
         cfg_q   <= cfg_d;
         clr_q   <= clr_d;
         stop_q  <= stop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         abort_q <= abort_d;
      end
   end

   assign {wr_mode, data_mode, len_random_en, fix_wr_len,
           read_repeat_num, data_order, dq_inversion} = cfg_q;
   assign bist_stop   = stop_q;
   assign manu_clear  = (clr_q != '0);
   assign step_idx    = step_q;
   assign fail_mask   = fail_q[NUM_STEPS-1:0];
   assign seq_busy    = busy_q;
   assign seq_done    = done_q;
   assign seq_pass    = pass_q;
   assign seq_timeout = tmo_q;
   assign seq_state   = state_q;

endmodule

// File: tb/tb_dfi_bist_seq_ctrl_v1_0.sv
// Directed bench for dfi_bist_seq_ctrl_v1_0: two-step table, simple BIST responder with a 2-cycle run_led lag.
module tb_dfi_bist_seq_ctrl_v1_0;

   localparam logic [21:0] CFG0 = 22'h1ABC5A;
   localparam logic [21:0] CFG1 = 22'h2543A5;

   logic       core_clk = 1'b0;
   logic       core_clk_rst_n;
   logic       seq_start, seq_abort, ddrphy_init_done;
   logic       bist_run_led;
   logic [7:0] err_cnt;
   logic       err_flag_led;
   logic [1:0] wr_mode, data_mode;
   logic       len_random_en;
   logic [3:0] fix_wr_len, read_repeat_num;
   logic       data_order;
   logic [7:0] dq_inversion;
   logic       bist_stop, manu_clear;
   logic [3:0] step_idx;
   logic [1:0] fail_mask;
   logic       seq_busy, seq_done, seq_pass, seq_timeout;
   logic [2:0] seq_state;

   int n_chk = 0;
   int n_fail = 0;

   always #5 core_clk = ~core_clk;

   dfi_bist_seq_ctrl_v1_0 #(
      .NUM_STEPS   (2),
      .STEP_CFG    ({CFG1, CFG0}),
      .RUN_CYCLES  (24'd100),
      .SETTLE_CYC  (4),
      .STOP_TIMEOUT(4096)
   ) dut (
      .core_clk        (core_clk),
      .core_clk_rst_n  (core_clk_rst_n),
      .seq_start       (seq_start),
      .seq_abort       (seq_abort),
      .ddrphy_init_done(ddrphy_init_done),
      .bist_run_led    (bist_run_led),
      .err_cnt         (err_cnt),
      .err_flag_led    (err_flag_led),
      .wr_mode         (wr_mode),
      .data_mode       (data_mode),
      .len_random_en   (len_random_en),
      .fix_wr_len      (fix_wr_len),
      .read_repeat_num (read_repeat_num),
      .data_order      (data_order),
      .dq_inversion    (dq_inversion),
      .bist_stop       (bist_stop),
      .manu_clear      (manu_clear),
      .step_idx        (step_idx),
      .fail_mask       (fail_mask),
      .seq_busy        (seq_busy),
      .seq_done        (seq_done),
      .seq_pass        (seq_pass),
      .seq_timeout     (seq_timeout),
      .seq_state       (seq_state)
   );

   // BIST responder: run_led follows ~bist_stop two clocks late, optionally stuck high.
   logic [1:0] led_pipe;
   logic       led_stuck, inj_cnt_en, inj_flag_en;
   logic [3:0] inj_step;
   always @(posedge core_clk or negedge core_clk_rst_n)
      if (!core_clk_rst_n) led_pipe <= 2'b00;
      else                 led_pipe <= {led_pipe[0], ~bist_stop};
   assign bist_run_led = led_pipe[1] | led_stuck;
   assign err_cnt      = (inj_cnt_en && step_idx == inj_step) ? 8'd3 : 8'd0;
   assign err_flag_led = inj_flag_en && (step_idx == inj_step);

   logic [21:0] cfg_obs;
   assign cfg_obs = {wr_mode, data_mode, len_random_en, fix_wr_len,
                     read_repeat_num, data_order, dq_inversion};

   int run_lens[$];
   int run_cur, stop_cur, last_stop, clr_cur, last_clr, cfg_err, load1;

   always @(negedge core_clk) begin
      if (core_clk_rst_n) begin
         if (!bist_stop) begin
            run_cur = run_cur + 1;
            if (cfg_obs != ((step_idx == 4'd0) ? CFG0 : CFG1)) cfg_err = cfg_err + 1;
         end else if (run_cur != 0) begin
            run_lens.push_back(run_cur);
            run_cur = 0;
         end
         if (seq_state == 3'd5) stop_cur = stop_cur + 1;
         else if (stop_cur != 0) begin
            last_stop = stop_cur;
            stop_cur  = 0;
         end
         if (manu_clear) clr_cur = clr_cur + 1;
         else if (clr_cur != 0) begin
            last_clr = clr_cur;
            clr_cur  = 0;
         end
         if (seq_state == 3'd2 && step_idx == 4'd1) load1 = load1 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge core_clk);
   endtask

   task automatic clear_mon();
      run_lens.delete();
      run_cur = 0; stop_cur = 0; last_stop = 0;
      clr_cur = 0; last_clr = 0; cfg_err = 0; load1 = 0;
   endtask

   task automatic start_seq();
      seq_start = 1'b1;
      tick(1);
      seq_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i = 0;
      while (!seq_done && i < budget) begin
         tick(1);
         i++;
      end
      chk({tag, "_done"}, 32'(seq_done), 32'd1);
   endtask

   task automatic wait_run(input string tag, input int budget);
      int i = 0;
      while (bist_stop && i < budget) begin
         tick(1);
         i++;
      end
      chk({tag, "_run_seen"}, 32'(bist_stop), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      core_clk_rst_n = 1'b0;
      seq_start = 1'b0; seq_abort = 1'b0; ddrphy_init_done = 1'b0;
      led_stuck = 1'b0; inj_cnt_en = 1'b0; inj_flag_en = 1'b0; inj_step = 4'd0;
      clear_mon();
      tick(3);
      chk("rst_bist_stop", 32'(bist_stop), 32'd1);
      chk("rst_state",     32'(seq_state), 32'd0);
      chk("rst_cfg",       32'(cfg_obs), 32'd0);
      chk("rst_status",    32'({manu_clear, seq_busy, seq_done, seq_pass, seq_timeout}), 32'd0);
      chk("rst_idx_mask",  32'({step_idx, fail_mask}), 32'd0);
      core_clk_rst_n = 1'b1;
      tick(2);

      // Clean two-step sequence
      ddrphy_init_done = 1'b1;
      clear_mon();
      start_seq();
      chk("t1_busy",  32'(seq_busy), 32'd1);
      chk("t1_state", 32'(seq_state), 32'd1);
      wait_done("t1", 2000);
      chk("t1_pass",    32'(seq_pass), 32'd1);
      chk("t1_mask",    32'(fail_mask), 32'd0);
      chk("t1_busy0",   32'(seq_busy), 32'd0);
      chk("t1_tmo",     32'(seq_timeout), 32'd0);
      chk("t1_state7",  32'(seq_state), 32'd7);
      chk("t1_idx",     32'(step_idx), 32'd1);
      chk("t1_nruns",   32'(run_lens.size()), 32'd2);
      if (run_lens.size() == 2) begin
         chk("t1_run0_len", 32'(run_lens[0]), 32'd100);
         chk("t1_run1_len", 32'(run_lens[1]), 32'd100);
      end
      chk("t1_cfg_err",  32'(cfg_err), 32'd0);
      chk("t1_clr_len",  32'(last_clr), 32'd4);
      chk("t1_stop_len", 32'(last_stop), 32'd3);

      // err_cnt=3 during step 1
      inj_cnt_en = 1'b1; inj_step = 4'd1;
      clear_mon();
      start_seq();
      wait_done("t2", 2000);
      chk("t2_mask",    32'(fail_mask), 32'h2);
      chk("t2_pass",    32'(seq_pass), 32'd0);
      chk("t2_cfg_err", 32'(cfg_err), 32'd0);
      inj_cnt_en = 1'b0;

      // err_flag during step 0: sequence still runs step 1
      inj_flag_en = 1'b1; inj_step = 4'd0;
      clear_mon();
      start_seq();
      wait_done("t2b", 2000);
      chk("t2b_mask",  32'(fail_mask), 32'h1);
      chk("t2b_nruns", 32'(run_lens.size()), 32'd2);
      chk("t2b_idx",   32'(step_idx), 32'd1);
      inj_flag_en = 1'b0;

      // run_led stuck high: every STOP times out
      led_stuck = 1'b1;
      clear_mon();
      start_seq();
      wait_done("t3", 12000);
      chk("t3_tmo",      32'(seq_timeout), 32'd1);
      chk("t3_mask",     32'(fail_mask), 32'h3);
      chk("t3_pass",     32'(seq_pass), 32'd0);
      chk("t3_stop_len", 32'(last_stop), 32'd4096);
      chk("t3_nruns",    32'(run_lens.size()), 32'd2);
      led_stuck = 1'b0;

      // Abort mid-RUN of step 0
      clear_mon();
      start_seq();
      wait_run("t4", 200);
      tick(10);
      seq_abort = 1'b1;
      tick(1);
      seq_abort = 1'b0;
      chk("t4_stop_next", 32'(bist_stop), 32'd1);
      chk("t4_state5",    32'(seq_state), 32'd5);
      wait_done("t4", 200);
      chk("t4_pass",  32'(seq_pass), 32'd0);
      chk("t4_mask",  32'(fail_mask), 32'd0);
      chk("t4_idx",   32'(step_idx), 32'd0);
      chk("t4_load1", 32'(load1), 32'd0);
      chk("t4_nruns", 32'(run_lens.size()), 32'd1);
      if (run_lens.size() == 1) chk("t4_run_len", 32'(run_lens[0]), 32'd11);

      // Start with PHY init still pending
      ddrphy_init_done = 1'b0;
      clear_mon();
      start_seq();
      tick(20);
      chk("t5_state1", 32'(seq_state), 32'd1);
      chk("t5_stop",   32'(bist_stop), 32'd1);
      chk("t5_busy",   32'(seq_busy), 32'd1);
      ddrphy_init_done = 1'b1;
      tick(1);
      chk("t5_load", 32'(seq_state), 32'd2);
      wait_done("t5", 2000);
      chk("t5_pass", 32'(seq_pass), 32'd1);

      // Asynchronous reset in the middle of RUN
      start_seq();
      wait_run("t6", 200);
      tick(5);
      core_clk_rst_n = 1'b0;
      #1;
      chk("t6_stop",  32'(bist_stop), 32'd1);
      chk("t6_state", 32'(seq_state), 32'd0);
      chk("t6_busy",  32'(seq_busy), 32'd0);
      chk("t6_cfg",   32'(cfg_obs), 32'd0);
      tick(2);
      core_clk_rst_n = 1'b1;
      tick(2);

      // start and abort together in IDLE: abort wins
      seq_start = 1'b1;
      seq_abort = 1'b1;
      tick(1);
      seq_start = 1'b0;
      seq_abort = 1'b0;
      tick(2);
      chk("t7_state", 32'(seq_state), 32'd0);
      chk("t7_busy",  32'(seq_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
